// File: rtl/cnn_pool_pkg.sv
// Shared types and constants for the 2x2 max-pool streaming block.
package cnn_pool_pkg;

    // Row phase of the input stream; a transition happens only when the
    // last sample of a row is accepted.
    typedef enum logic [1:0] {
        ROW_EVEN = 2'd0,
        ROW_ODD  = 2'd1,
        ROW_DROP = 2'd2
    } pool_state_e;

    // Upper clamp bound for the optional 8-bit saturating output.
    localparam int SAT8_MAX = 255;

    // Counter/address width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_row_buf.sv
// Row buffer holding the horizontal pair maxima of the most recent even row.
// One synchronous write port, one asynchronous read port, contents not reset.
module pool_row_buf
    import cnn_pool_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 13,
    localparam int AW         = clog2_min1(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store one pair maximum per write strobe.
    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 / stride-2 max pooling over a row-major feature map.
// Even rows store horizontal pair maxima in a row buffer; odd rows combine
// their pair maxima with the buffered ones and emit one pooled sample each.
// A trailing odd column and a trailing odd row are consumed but produce
// nothing. Optional build macro: POOL2X2_SAT8_EN clamps outputs to [0,255].
module pool2x2_stream
    import cnn_pool_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_W      = 26,
    parameter int IMG_H      = 26
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic signed [DATA_WIDTH-1:0] in_data_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic signed [DATA_WIDTH-1:0] out_data_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         frame_done_o
);

    localparam int OUT_W = IMG_W / 2;
    localparam int OUT_H = IMG_H / 2;
    localparam int CW    = clog2_min1(IMG_W);
    localparam int RW    = clog2_min1(IMG_H);
    localparam int AW    = clog2_min1(OUT_W);
    localparam bit H_ODD = (IMG_H % 2) == 1;

    localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_OUT_LAST = CW'(2 * OUT_W - 1);
    localparam logic [RW-1:0] ROW_OUT_LAST = RW'(2 * OUT_H - 1);
    localparam logic [RW-1:0] ROW_PRE_DROP = RW'(IMG_H - 2);

    pool_state_e state_q, state_d;

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          accept, odd_col, col_last, last_win;
    logic          buf_we, out_load, out_last_q;
    logic [AW-1:0] buf_addr;

    logic signed [DATA_WIDTH-1:0] pair_q, pair_max, rb_rdata, win_max, out_next;
    logic        [DATA_WIDTH-1:0] rb_raw;

    // Stall input only while a result is held and not being taken.
    assign in_ready_o = !(out_valid_o && !out_ready_i);
    assign accept     = in_valid_i && in_ready_o && !clear_i;
    assign odd_col    = col_q[0];
    assign col_last   = (col_q == COL_LAST);
    assign last_win   = (row_q == ROW_OUT_LAST) && (col_q == COL_OUT_LAST);
    assign buf_addr   = AW'(col_q >> 1);

    assign pair_max = (in_data_i > pair_q) ? in_data_i : pair_q;
    assign rb_rdata = $signed(rb_raw);
    assign win_max  = (rb_rdata > pair_max) ? rb_rdata : pair_max;

`ifdef POOL2X2_SAT8_EN
    // Clamp the window maximum to an unsigned byte range.
    always_comb begin
        out_next = win_max;
        if (win_max[DATA_WIDTH-1])
            out_next = '0;
        else if (win_max > $signed(DATA_WIDTH'(SAT8_MAX)))
            out_next = DATA_WIDTH'(SAT8_MAX);
    end
`else
    assign out_next = win_max;
`endif

    pool_row_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OUT_W)
    ) u_row_buf (
        .clk_i   (clk_i),
        .we_i    (buf_we),
        .waddr_i (buf_addr),
        .wdata_i (pair_max),
        .raddr_i (buf_addr),
        .rdata_o (rb_raw)
    );

    // Row-phase state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ROW_EVEN;
        else         state_q <= state_d;
    end

    // Next row phase plus per-sample buffer write / output load strobes.
    always_comb begin
        state_d  = state_q;
        buf_we   = 1'b0;
        out_load = 1'b0;
        if (accept) begin
            unique case (state_q)
                ROW_EVEN: begin
                    buf_we = odd_col;
                    if (col_last) state_d = ROW_ODD;
                end
                ROW_ODD: begin
                    out_load = odd_col;
                    if (col_last)
                        state_d = (H_ODD && row_q == ROW_PRE_DROP) ? ROW_DROP : ROW_EVEN;
                end
                ROW_DROP: begin
                    if (col_last) state_d = ROW_EVEN;
                end
                default: state_d = ROW_EVEN;
            endcase
        end
        if (clear_i) state_d = ROW_EVEN;
    end

    // Input position counters, row-major with wrap at frame end.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
        end else if (clear_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Hold the even-column sample until its odd partner arrives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                  pair_q <= '0;
        else if (accept && !odd_col)  pair_q <= in_data_i;
    end

    // Output register: load on a finished window, hold until handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_q  <= 1'b0;
        end else if (clear_i) begin
            out_valid_o <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (out_load) begin
            out_valid_o <= 1'b1;
            out_data_o  <= out_next;
            out_last_q  <= last_win;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    // Pulse once the final pooled sample of the frame has been taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      frame_done_o <= 1'b0;
        else if (clear_i) frame_done_o <= 1'b0;
        else              frame_done_o <= out_valid_o && out_ready_i && out_last_q;
    end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Scoreboard bench for pool2x2_stream: a 4x4 and a 5x5 instance, exercised
// one at a time. Expected pooled values come from a window-level model.
module tb_pool2x2_stream;

    localparam int DW = 32;

    typedef struct {
        int val;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic                 clr   [2];
    logic signed [DW-1:0] idata [2];
    logic                 ivld  [2];
    logic                 irdy  [2];
    logic signed [DW-1:0] odata [2];
    logic                 ovld  [2];
    logic                 ordy  [2];
    logic                 fd    [2];

    int   act       = 0;
    int   rmode     = 0;
    int   n_cmp     = 0;
    int   n_err     = 0;
    int   stall_cnt = 0;
    bit   fd_pend   = 1'b0;
    exp_t exp_q [$];
    int   smp   [$];

    always #5 clk = ~clk;

    pool2x2_stream #(.DATA_WIDTH(DW), .IMG_W(4), .IMG_H(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr[0]),
        .in_data_i(idata[0]), .in_valid_i(ivld[0]), .in_ready_o(irdy[0]),
        .out_data_o(odata[0]), .out_valid_o(ovld[0]), .out_ready_i(ordy[0]),
        .frame_done_o(fd[0]));

    pool2x2_stream #(.DATA_WIDTH(DW), .IMG_W(5), .IMG_H(5)) u_dut5 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr[1]),
        .in_data_i(idata[1]), .in_valid_i(ivld[1]), .in_ready_o(irdy[1]),
        .out_data_o(odata[1]), .out_valid_o(ovld[1]), .out_ready_i(ordy[1]),
        .frame_done_o(fd[1]));

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Downstream ready: 0 always ready, 1 random, 2 stall 3 cycles on first
    // valid, 3 never ready.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            case (rmode)
                1: ordy[k] = ($urandom_range(0, 3) != 0);
                2: begin
                    if (k == act && ovld[k] && stall_cnt < 3) begin
                        ordy[k] = 1'b0;
                        stall_cnt++;
                    end else begin
                        ordy[k] = 1'b1;
                    end
                end
                3: ordy[k] = 1'b0;
                default: ordy[k] = 1'b1;
            endcase
        end
        if (rmode != 2) stall_cnt = 0;
    end

    // Monitor: pop and compare on each output handshake, check held data
    // during stalls and the frame_done pulse after the last output.
    always @(negedge clk) begin
        int   k;
        exp_t e;
        k = act;
        if (!rst_n) begin
            fd_pend = 1'b0;
        end else begin
            if (fd[k] || fd_pend) check("frame_done", fd[k], fd_pend);
            fd_pend = 1'b0;
            if (ovld[k] && ordy[k]) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got %0d, required no output", odata[k]);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", odata[k], e.val);
                    fd_pend = e.last;
                end
            end else if (ovld[k]) begin
                check("stall_in_ready", irdy[k], 0);
                if (exp_q.size() != 0) check("stall_hold", odata[k], exp_q[0].val);
            end
        end
    end

    function automatic int rand_val();
        if ($urandom_range(0, 3) == 0) return int'($urandom);
        return int'($urandom_range(0, 600)) - 300;
    endfunction

    // Reference: every complete 2x2 window among the first n samples yields
    // the max of its four samples, in row-major window order.
    task automatic expect_frame(input int w, input int h, input int n);
        for (int oy = 0; oy < h / 2; oy++) begin
            for (int ox = 0; ox < w / 2; ox++) begin
                int   m;
                exp_t e;
                if ((2 * oy + 1) * w + 2 * ox + 1 < n) begin
                    m = smp[2 * oy * w + 2 * ox];
                    if (smp[2 * oy * w + 2 * ox + 1] > m)       m = smp[2 * oy * w + 2 * ox + 1];
                    if (smp[(2 * oy + 1) * w + 2 * ox] > m)     m = smp[(2 * oy + 1) * w + 2 * ox];
                    if (smp[(2 * oy + 1) * w + 2 * ox + 1] > m) m = smp[(2 * oy + 1) * w + 2 * ox + 1];
`ifdef POOL2X2_SAT8_EN
                    if (m < 0)   m = 0;
                    if (m > 255) m = 255;
`endif
                    e.val  = m;
                    e.last = (n == w * h) && (oy == h / 2 - 1) && (ox == w / 2 - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic send(input int k, input int d);
        int t;
        t = 0;
        idata[k] = d;
        ivld[k]  = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!irdy[k] && t < 500);
        if (!irdy[k]) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready low for %0d cycles, required high", t);
        end
        @(posedge clk);
        #1;
        ivld[k] = 1'b0;
    endtask

    // kind: 0 ramp, 1 random, 2 all -3 with one -1 per window.
    task automatic run_frame(input int k, input int w, input int h, input int kind,
                             input int n, input bit gaps);
        smp.delete();
        for (int i = 0; i < w * h; i++) begin
            case (kind)
                0:       smp.push_back(i);
                1:       smp.push_back(rand_val());
                default: smp.push_back(-3);
            endcase
        end
        if (kind == 2) begin
            for (int oy = 0; oy < h / 2; oy++)
                for (int ox = 0; ox < w / 2; ox++) begin
                    int r;
                    r = int'($urandom_range(0, 3));
                    smp[(2 * oy + r / 2) * w + 2 * ox + r % 2] = -1;
                end
        end
        expect_frame(w, h, n);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(k, smp[i]);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d outputs outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            clr[k]   = 1'b0;
            ivld[k]  = 1'b0;
            idata[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("reset_out_valid", ovld[k], 0);
            check("reset_out_data", odata[k], 0);
            check("reset_frame_done", fd[k], 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check("reset_in_ready", irdy[k], 1);

        // 4x4 ramp, free-flowing
        act   = 0;
        rmode = 0;
        run_frame(0, 4, 4, 0, 16, 1'b0);
        drain();

        // 4x4 ramp with a 3-cycle stall on the first output
        rmode = 2;
        run_frame(0, 4, 4, 0, 16, 1'b0);
        drain();
        rmode = 0;

        // negative samples
        run_frame(0, 4, 4, 2, 16, 1'b0);
        drain();

        // abort after 6 samples; clear with a live input that must be ignored
        run_frame(0, 4, 4, 0, 6, 1'b0);
        idata[0] = 999;
        ivld[0]  = 1'b1;
        clr[0]   = 1'b1;
        @(posedge clk);
        #1;
        clr[0]  = 1'b0;
        ivld[0] = 1'b0;
        run_frame(0, 4, 4, 0, 16, 1'b0);
        drain();

        // asynchronous reset while an output is held
        rmode = 3;
        repeat (2) begin @(posedge clk); #1; end
        run_frame(0, 4, 4, 0, 6, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset_valid", ovld[0], 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", ovld[0], 0);
        check("async_reset_data", odata[0], 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rmode = 0;
        run_frame(0, 4, 4, 0, 16, 1'b0);
        drain();

        // random data, random gaps and backpressure
        rmode = 1;
        repeat (6) run_frame(0, 4, 4, 1, 16, 1'b1);
        run_frame(0, 4, 4, 2, 16, 1'b1);
        drain();

        // 5x5: odd column and odd row dropped
        act   = 1;
        rmode = 0;
        run_frame(1, 5, 5, 0, 25, 1'b0);
        drain();
        rmode = 1;
        repeat (4) run_frame(1, 5, 5, 1, 25, 1'b1);
        run_frame(1, 5, 5, 2, 25, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pool2x2_stream.md
POOL2X2_STREAM -- requirements
Module: pool2x2_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of signed input/output samples.
REQ-002 SHALL have parameter IMG_W, default 26, input feature-map width in samples (>=2).
REQ-003 SHALL have parameter IMG_H, default 26, input feature-map height in rows (>=2).
REQ-004 SHALL have port clk_i  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clear_i  input  1  synchronous frame abort/restart.
REQ-007 SHALL have port in_data_i  input  DATA_WIDTH  signed ReLU sample, row-major order.
REQ-008 SHALL have port in_valid_i  input  1  in_data_i valid.
REQ-009 SHALL have port in_ready_o  output  1  block accepts sample this cycle.
REQ-010 SHALL have port out_data_o  output  DATA_WIDTH  signed pooled sample.
REQ-011 SHALL have port out_valid_o  output  1  out_data_o valid.
REQ-012 SHALL have port out_ready_i  input  1  downstream accepts sample.
REQ-013 SHALL have port frame_done_o  output  1  one-cycle pulse after last pooled sample of a frame handshakes.

Function
REQ-014 SHALL compute non-overlapping 2x2 max, stride 2; output map floor(IMG_W/2) x floor(IMG_H/2), row-major.
REQ-015 SHALL accept an input sample only when in_valid_i && in_ready_o; in_ready_o = !(out_valid_o && !out_ready_i).
REQ-016 SHALL track input position with col counter (0..IMG_W-1) and row counter (0..IMG_H-1), wrapping col to 0 and incrementing row at IMG_W-1, wrapping row to 0 at end of frame.
REQ-017 SHALL implement states ROW_EVEN (row even), ROW_ODD (row odd), ROW_DROP (last row when IMG_H odd); transitions only on accept of the col=IMG_W-1 sample.
REQ-018 SHALL in every state latch the even-column sample into a pair register; on odd column form pair_max = max(pair register, sample), signed compare.
REQ-019 SHALL in ROW_EVEN write pair_max to row buffer entry col/2.
REQ-020 SHALL in ROW_ODD load out_data_o = max(pair_max, row buffer[col/2]) and assert out_valid_o the cycle after accept (latency 1).
REQ-021 SHALL hold out_data_o/out_valid_o stable until out_valid_o && out_ready_i; simultaneous handshake and new result reloads register without bubble.
REQ-022 SHALL discard the last column when IMG_W odd and all ROW_DROP samples (accepted, no output).
REQ-023 SHALL pulse frame_done_o the cycle after the handshake of output (floor(IMG_H/2)-1, floor(IMG_W/2)-1).
REQ-024 SHALL on clear_i return counters to 0, state to ROW_EVEN, drop out_valid_o and ignore in_valid_i that cycle; clear_i wins over simultaneous accept.

Reset
REQ-025 SHALL on rst_ni low: out_valid_o=0, out_data_o=0, frame_done_o=0, in_ready_o=1 after reset, counters 0, state ROW_EVEN; row buffer contents not reset.

Configuration
REQ-026 SHALL, with POOL2X2_SAT8_EN defined, saturate out_data_o to [0,255] (negatives to 0, >255 to 255); without it pass full DATA_WIDTH max unchanged.

Structure
REQ-027 SHALL place state typedef pool_state_e and shared constants in package cnn_pool_pkg.
REQ-028 SHALL implement row buffer as sub-module pool_row_buf (floor(IMG_W/2) entries, DATA_WIDTH, 1 write, 1 async read).

Verification (IMG_W=4, IMG_H=4 unless noted)
REQ-029 SHALL cover ramp 0..15 with continuous valid/ready -> outputs 5,7,13,15 then frame_done_o pulse.
REQ-030 SHALL cover out_ready_i low 3 cycles while first output 5 valid -> in_ready_o low, out_data_o held at 5, no sample lost.
REQ-031 SHALL cover negative samples all -3 except one -1 per window -> every output -1 (POOL2X2_SAT8_EN undefined) and 0 (defined).
REQ-032 SHALL cover IMG_W=5, IMG_H=5, ramp 0..24 -> outputs 6,8,16,18; column 4 and row 4 dropped; frame_done_o after 18.
REQ-033 SHALL cover clear_i asserted after 6 accepted samples, then ramp 0..15 -> outputs 5,7,13,15, no stale data.
REQ-034 SHALL cover rst_ni asserted mid-frame with out_valid_o high -> out_valid_o=0 immediately, next frame correct.
